dcache_wbuf_axi: RTL and testbench
==================================

# dcache_wbuf_axi

Write-back buffer sitting between the data-cache main FSM and the AXI write channel. Captures a victim line (or one uncached store word) when the FSM loads it, then performs the AXI AW/W/B transaction when the FSM raises its write request. Reports address acceptance and transaction completion back to the FSM. The buffer is single-entry: one outstanding write at a time.

## Interface
- `ADDR_W`, 32, address width
- `LINE_WORDS`, 16, 32-bit words per cache line; max burst is `LINE_WORDS` beats
- `AXI_ID`, 4'd1, constant `awid`

- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `wbuf_we`  in  1  capture `line_in`, `addr_in`, `wstrb_in`
- `wbuf_reset`  in  1  clear `wrt_finish`, return to IDLE
- `line_in`  in  32*LINE_WORDS  victim line, word 0 at bits [31:0]; uncached store data is lane-aligned in word 0
- `addr_in`  in  ADDR_W  write address; line-aligned for cached, exact for uncached
- `wstrb_in`  in  4  byte strobe for single-beat writes
- `w_req`  in  1  FSM write request; held until `w_rdy`
- `w_length`  in  8  AXI len, sampled with `w_req`
- `w_size`  in  3  AXI size, sampled with `w_req`
- `w_rdy`  out  1  AW handshake this cycle
- `wrt_finish`  out  1  transaction complete; sticky
- `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awvalid`  out  4/ADDR_W/8/3/2/1  AXI AW channel
- `awready`  in  1  AXI AW channel
- `wdata`, `wstrb`, `wlast`, `wvalid`  out  32/4/1/1  AXI W channel
- `wready`  in  1  AXI W channel
- `bvalid`  in  1  AXI B channel
- `bresp`  in  2  AXI B channel
- `bready`  out  1  AXI B channel

## Operation
- States: IDLE, AW, W, B, DONE.
- `wbuf_we` is honoured in IDLE and DONE only. It loads the line, address and strobe registers.
  - In DONE it also clears `wrt_finish` and moves to IDLE.
  - In AW, W or B it is ignored; the data registers stay stable.
- IDLE → AW on `w_req`. The same edge latches `w_length` → `awlen` and `w_size` → `awsize`.
- AW: `awvalid`=1, `awaddr`=address register, `awburst`=INCR (2'b01).
  - `w_rdy` = `awready`, combinational in AW only.
  - On `awvalid && awready` go to W with beat counter = 0.
- W: `wvalid`=1, `wdata` = line word[counter].
  - `wstrb` = 4'hF when `awlen`≠0, else `wstrb_in` register.
  - `wlast` = (counter == `awlen`).
  - Counter increments on `wvalid && wready`.
  - The handshake on `wlast` moves to B.
- B: `bready`=1. On `bvalid` set `wrt_finish` and go to DONE. `bresp` is ignored.
- DONE: `wrt_finish` holds 1 until `wbuf_reset` or `wbuf_we`.
- `wbuf_reset` in any state forces IDLE and clears `wrt_finish`.
  - It is not to be issued mid-burst; if it is, AXI outputs drop immediately and the protocol violation is the FSM's fault.
- `w_req` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, except `awburst`=2'b01 and `awid`=`AXI_ID`. State = IDLE, counter = 0, data registers = 0.
- `w_req` at cycle N (IDLE) → `awvalid` at N+1.
- `awready` already high gives the AW handshake at N+1, the first W beat at N+2, and the last beat at N+2+`awlen` with zero-wait `wready`.
- `bvalid` at cycle M → `wrt_finish` high from M+1.
- `wvalid` is never asserted before the AW handshake.
- `awvalid` and `wvalid` are never high in the same cycle.
- Once asserted, `awvalid` and `wvalid` hold with stable payload until their handshakes complete.
- Counter width is clog2(`LINE_WORDS`). `awlen` ≥ `LINE_WORDS` is illegal and unchecked.
- `wbuf_we` and `wbuf_reset` in the same cycle in DONE: the load happens, `wrt_finish` clears, state = IDLE.

## Configuration
- `DCACHE_WBUF_EARLY_FINISH_EN`
  - Defined: `wrt_finish` is set on the `wlast` handshake and the state goes directly to DONE.
    - B is still accepted: `bready` is held 1 in DONE until `bvalid`, tracked by an internal pending flag.
    - A new `w_req` is not taken while the flag is set.
  - Undefined: `wrt_finish` is set on `bvalid`, as in Operation.

## Test plan
- Reset mid-burst: assert `rst` asynchronously during beat 5 → all AXI valids 0 and `wrt_finish`=0 in the same cycle; state IDLE after release.
- Cached 16-beat write, `line_in` word k = 32'h1000_0000+k, `addr_in`=32'h8000_0040, `w_length`=15, `w_size`=2, zero-wait slave → `awaddr`=32'h8000_0040, 16 beats with `wdata` 32'h1000_0000..32'h1000_000F, `wlast` only on beat 16, `wrt_finish` one cycle after `bvalid`.
- Uncached byte store: `addr_in`=32'h1FE0_01E1, `wstrb_in`=4'b0010, `w_length`=0, `w_size`=0 → `awlen`=0, `awsize`=0, one beat with `wstrb`=4'b0010 and `wlast`=1.
- Backpressure: `awready` low for 3 cycles, `wready` toggling 1-0-1 → `w_rdy` pulses exactly once, payload stable while waiting, no beat dropped or repeated.
- Ignored load: `wbuf_we` with new data while in W → remaining beats still carry the original line.
- DONE handling: `wrt_finish` held across 10 idle cycles, then `wbuf_reset` → 0 next cycle. With `DCACHE_WBUF_EARLY_FINISH_EN` defined, `wrt_finish` rises the cycle after the last beat, before `bvalid`.

Source files
------------

// File: rtl/dcache_wbuf_axi.sv
// Single-entry write-back buffer between the D-cache FSM and the AXI AW/W/B channels.
// Optional build macro DCACHE_WBUF_EARLY_FINISH_EN: report completion on the last W beat, drain B in the background.
module dcache_wbuf_axi #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_WORDS = 16,
  parameter logic [3:0]  AXI_ID     = 4'd1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wbuf_we,
  input  logic                       wbuf_reset,
  input  logic [32*LINE_WORDS-1:0]   line_in,
  input  logic [ADDR_W-1:0]          addr_in,
  input  logic [3:0]                 wstrb_in,
  input  logic                       w_req,
  input  logic [7:0]                 w_length,
  input  logic [2:0]                 w_size,
  output logic                       w_rdy,
  output logic                       wrt_finish,
  output logic [3:0]                 awid,
  output logic [ADDR_W-1:0]          awaddr,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic                       bvalid,
  input  logic [1:0]                 bresp,
  output logic                       bready
);

  localparam int unsigned CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [LINE_WORDS-1:0][31:0] line_q, line_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [3:0]                  strb_q, strb_d;
  logic [7:0]                  len_q, len_d;
  logic [2:0]                  size_q, size_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        fin_q, fin_d;
  logic                        last_beat;
  logic                        b_pend;

`ifdef DCACHE_WBUF_EARLY_FINISH_EN
  logic pend_q, pend_d;
  assign b_pend = pend_q;
`else
  assign b_pend = 1'b0;
`endif

  // bresp carries no information the cache FSM acts on
  logic unused_bresp;
  assign unused_bresp = ^bresp;

  assign last_beat = (len_q == 8'(cnt_q));

  // Next-state and datapath capture
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    len_d   = len_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
`ifdef DCACHE_WBUF_EARLY_FINISH_EN
    pend_d  = pend_q;
    if (pend_q && bvalid) pend_d = 1'b0;
`endif

    // Data registers only change while no transaction is using them
    if (wbuf_we && (state_q == S_IDLE || state_q == S_DONE)) begin
      line_d = line_in;
      addr_d = addr_in;
      strb_d = wstrb_in;
    end

    case (state_q)
      S_IDLE: begin
        if (w_req && !b_pend) begin
          state_d = S_AW;
          len_d   = w_length;
          size_d  = w_size;
        end
      end
      S_AW: begin
        if (awready) begin
          state_d = S_W;
          cnt_d   = '0;
        end
      end
      S_W: begin
        if (wready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
`ifdef DCACHE_WBUF_EARLY_FINISH_EN
            state_d = S_DONE;
            fin_d   = 1'b1;
            pend_d  = 1'b1;
`else
            state_d = S_B;
`endif
          end
        end
      end
      S_B: begin
        if (bvalid) begin
          state_d = S_DONE;
          fin_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (wbuf_we) begin
          state_d = S_IDLE;
          fin_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wbuf_reset) begin
      state_d = S_IDLE;
      fin_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      len_q   <= len_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
    end
  end

`ifdef DCACHE_WBUF_EARLY_FINISH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end
`endif

  // Channel outputs decode straight from registered state
  assign awid       = AXI_ID;
  assign awburst    = 2'b01;
  assign awaddr     = addr_q;
  assign awlen      = len_q;
  assign awsize     = size_q;
  assign awvalid    = (state_q == S_AW);
  assign w_rdy      = (state_q == S_AW) && awready;
  assign wvalid     = (state_q == S_W);
  assign wdata      = line_q[cnt_q];
  assign wstrb      = (len_q != 8'd0) ? 4'hF : strb_q;
  assign wlast      = (state_q == S_W) && last_beat;
  assign bready     = (state_q == S_B) || b_pend;
  assign wrt_finish = fin_q;

endmodule

// File: tb/tb_dcache_wbuf_axi.sv
// Scoreboard bench for dcache_wbuf_axi: expected AW/W traffic queued at stimulus, checked at handshake.
module tb_dcache_wbuf_axi;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LW     = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wbuf_we = 1'b0, wbuf_reset = 1'b0;
  logic [32*LW-1:0]     line_in = '0;
  logic [ADDR_W-1:0]    addr_in = '0;
  logic [3:0]           wstrb_in = '0;
  logic                 w_req = 1'b0;
  logic [7:0]           w_length = '0;
  logic [2:0]           w_size = '0;
  logic                 w_rdy, wrt_finish;
  logic [3:0]           awid;
  logic [ADDR_W-1:0]    awaddr;
  logic [7:0]           awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic                 awvalid;
  logic                 awready = 1'b0;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wlast, wvalid;
  logic                 wready = 1'b0;
  logic                 bvalid = 1'b0;
  logic [1:0]           bresp = 2'b00;
  logic                 bready;

  dcache_wbuf_axi dut (
    .clk(clk), .rst(rst), .wbuf_we(wbuf_we), .wbuf_reset(wbuf_reset),
    .line_in(line_in), .addr_in(addr_in), .wstrb_in(wstrb_in),
    .w_req(w_req), .w_length(w_length), .w_size(w_size),
    .w_rdy(w_rdy), .wrt_finish(wrt_finish),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } aw_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_exp_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];

  int vectors = 0;
  int miscompares = 0;
  int wrdy_cnt = 0;

  logic [LW-1:0][31:0] model_line = '0;
  logic [31:0]         model_addr = '0;
  logic [3:0]          model_strb = '0;

  logic        prev_awv = 1'b0, prev_awr = 1'b0, prev_wv = 1'b0, prev_wr = 1'b0, prev_wlast = 1'b0;
  logic [31:0] prev_awaddr = '0, prev_wdata = '0;
  logic [3:0]  prev_wstrb = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: pops the scoreboard and checks hold/stability rules
  always @(negedge clk) begin
    if (rst) begin
      prev_awv <= 1'b0;
      prev_wv  <= 1'b0;
    end else begin
      chk("aw_w_exclusive", 64'(awvalid && wvalid), 64'(0));
      chk("w_rdy", 64'(w_rdy), 64'(awvalid && awready));
      if (prev_awv && !prev_awr) begin
        chk("awvalid_hold", 64'(awvalid), 64'(1));
        chk("awaddr_stable", 64'(awaddr), 64'(prev_awaddr));
      end
      if (prev_wv && !prev_wr) begin
        chk("wvalid_hold", 64'(wvalid), 64'(1));
        chk("wdata_stable", 64'(wdata), 64'(prev_wdata));
        chk("wstrb_stable", 64'(wstrb), 64'(prev_wstrb));
        chk("wlast_stable", 64'(wlast), 64'(prev_wlast));
      end
      if (w_rdy) wrdy_cnt <= wrdy_cnt + 1;
      if (awvalid && awready) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
        else begin
          chk("awaddr", 64'(awaddr), 64'(aw_q[0].addr));
          chk("awlen", 64'(awlen), 64'(aw_q[0].len));
          chk("awsize", 64'(awsize), 64'(aw_q[0].size));
          chk("awburst", 64'(awburst), 64'(2'b01));
          chk("awid", 64'(awid), 64'(4'd1));
          void'(aw_q.pop_front());
        end
      end
      if (wvalid && wready) begin
        if (w_q.size() == 0) chk("w_unexpected", 64'(1), 64'(0));
        else begin
          chk("wdata", 64'(wdata), 64'(w_q[0].data));
          chk("wstrb", 64'(wstrb), 64'(w_q[0].strb));
          chk("wlast", 64'(wlast), 64'(w_q[0].last));
          void'(w_q.pop_front());
        end
      end
      prev_awv    <= awvalid;
      prev_awr    <= awready;
      prev_awaddr <= awaddr;
      prev_wv     <= wvalid;
      prev_wr     <= wready;
      prev_wdata  <= wdata;
      prev_wstrb  <= wstrb;
      prev_wlast  <= wlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] s);
    model_addr = a;
    model_strb = s;
    line_in    = model_line;
    addr_in    = a;
    wstrb_in   = s;
    wbuf_we    = 1'b1;
    tick();
    wbuf_we    = 1'b0;
  endtask

  task automatic push_exp(input int len, input int size);
    w_exp_t e;
    aw_q.push_back('{addr: model_addr, len: 8'(len), size: 3'(size)});
    for (int k = 0; k <= len; k++) begin
      e.data = model_line[k];
      e.strb = (len != 0) ? 4'hF : model_strb;
      e.last = (k == len);
      w_q.push_back(e);
    end
  endtask

  task automatic do_write(input int len, input int size, input int aw_wait,
                          input bit toggle, input bit ignored, input int b_wait);
    int n;
    int w0;
    w0 = wrdy_cnt;
    push_exp(len, size);
    w_req = 1'b1; w_length = 8'(len); w_size = 3'(size);
    tick();
    chk("awvalid_after_req", 64'(awvalid), 64'(1));
    n = 0;
    while (!wvalid && n < 50) begin
      awready = (n >= aw_wait);
      tick();
      n++;
    end
    awready = 1'b0; w_req = 1'b0;
    chk("aw_phase_cycles", 64'(n), 64'(aw_wait + 1));
    n = 0;
    while (wvalid && n < 200) begin
      wready = toggle ? (n % 2 == 0) : 1'b1;
      if (ignored && n == 2) begin
        line_in  = ~model_line;
        addr_in  = 32'hDEAD_0000;
        wstrb_in = 4'h5;
        wbuf_we  = 1'b1;
      end
      tick();
      wbuf_we = 1'b0;
      n++;
    end
    wready = 1'b0;
    chk("w_phase_cycles", 64'(n), 64'(toggle ? 2 * len + 1 : len + 1));
`ifdef DCACHE_WBUF_EARLY_FINISH_EN
    chk("finish_early", 64'(wrt_finish), 64'(1));
`else
    chk("finish_before_b", 64'(wrt_finish), 64'(0));
`endif
    for (int i = 0; i < b_wait; i++) begin
      chk("bready_wait", 64'(bready), 64'(1));
      tick();
    end
    chk("bready_at_b", 64'(bready), 64'(1));
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    chk("finish_after_b", 64'(wrt_finish), 64'(1));
    chk("bready_drop", 64'(bready), 64'(0));
    chk("aw_q_drained", 64'(aw_q.size()), 64'(0));
    chk("w_q_drained", 64'(w_q.size()), 64'(0));
    chk("w_rdy_pulses", 64'(wrdy_cnt - w0), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    chk("rst_awvalid", 64'(awvalid), 64'(0));
    chk("rst_wvalid", 64'(wvalid), 64'(0));
    chk("rst_bready", 64'(bready), 64'(0));
    chk("rst_finish", 64'(wrt_finish), 64'(0));
    chk("rst_w_rdy", 64'(w_rdy), 64'(0));
    chk("rst_awburst", 64'(awburst), 64'(2'b01));
    chk("rst_awid", 64'(awid), 64'(4'd1));
    chk("rst_awaddr", 64'(awaddr), 64'(0));
    chk("rst_awlen", 64'(awlen), 64'(0));
    chk("rst_awsize", 64'(awsize), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_wstrb", 64'(wstrb), 64'(0));
    chk("rst_wlast", 64'(wlast), 64'(0));
    rst = 1'b0;
    tick();

    // Cached 16-beat line, zero-wait slave, then DONE hold and wbuf_reset
    for (int k = 0; k < LW; k++) model_line[k] = 32'h1000_0000 + 32'(k);
    load(32'h8000_0040, 4'hF);
    do_write(15, 2, 0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 10; i++) begin
      chk("finish_hold", 64'(wrt_finish), 64'(1));
      tick();
    end
    wbuf_reset = 1'b1;
    tick();
    wbuf_reset = 1'b0;
    chk("finish_clear_reset", 64'(wrt_finish), 64'(0));

    // Uncached byte store in lane 1
    model_line = '0;
    model_line[0] = 32'h0000_5A00;
    load(32'h1FE0_01E1, 4'b0010);
    do_write(0, 0, 0, 1'b0, 1'b0, 0);

    // Backpressure: load from DONE, awready late, wready toggling
    for (int k = 0; k < LW; k++) model_line[k] = 32'h2000_0000 + 32'(k);
    load(32'h8000_1000, 4'hF);
    chk("finish_clear_load", 64'(wrt_finish), 64'(0));
    do_write(3, 2, 3, 1'b1, 1'b0, 1);

    // Load attempted mid-burst must not disturb the beats
    for (int k = 0; k < LW; k++) model_line[k] = 32'h3000_0000 + 32'(k);
    load(32'h8000_0100, 4'hF);
    do_write(7, 2, 0, 1'b0, 1'b1, 0);

    // Asynchronous reset during beat 5
    for (int k = 0; k < LW; k++) model_line[k] = 32'h4000_0000 + 32'(k);
    load(32'h8000_2000, 4'hF);
    push_exp(15, 2);
    w_req = 1'b1; w_length = 8'd15; w_size = 3'd2;
    tick();
    awready = 1'b1;
    tick();
    awready = 1'b0; w_req = 1'b0; wready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("midburst_wvalid", 64'(wvalid), 64'(1));
    chk("midburst_wdata", 64'(wdata), 64'(32'h4000_0005));
    rst = 1'b1;
    #1;
    chk("arst_awvalid", 64'(awvalid), 64'(0));
    chk("arst_wvalid", 64'(wvalid), 64'(0));
    chk("arst_wlast", 64'(wlast), 64'(0));
    chk("arst_bready", 64'(bready), 64'(0));
    chk("arst_finish", 64'(wrt_finish), 64'(0));
    wready = 1'b0;
    tick();
    rst = 1'b0;
    aw_q.delete();
    w_q.delete();
    tick();
    chk("post_rst_awvalid", 64'(awvalid), 64'(0));
    chk("post_rst_wvalid", 64'(wvalid), 64'(0));
    chk("post_rst_wdata", 64'(wdata), 64'(0));
    model_line = '0;
    model_addr = '0;
    model_strb = '0;
    do_write(0, 0, 0, 1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
